// File: rtl/neural_arb_pkg.sv
// Shared types and constants for the mac_core access arbiter.
// Optional grant statistics are built only when ARB_STATS_EN is defined.
package neural_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DRAIN,
    GAP
  } arb_state_t;

  localparam int DATA_W_DEFAULT = 16;
  localparam int STAT_W         = 16;

  function automatic logic [STAT_W-1:0] sat_inc(
    input logic [STAT_W-1:0] v
  );
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/mac_access_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester after last, wrapping.
// Produces one-hot pick, its index and an any-request flag.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx,
  output logic          any
);

  int c;

  always_comb begin
    pick = '0;
    idx  = '0;
    any  = 1'b0;
    c    = 0;
    for (int i = 1; i <= N; i++) begin
      c = (int'(last) + i) % N;
      if (!any && req[c]) begin
        any     = 1'b1;
        pick[c] = 1'b1;
        idx     = IW'(c);
      end
    end
  end

endmodule

// File: rtl/mac_access_arbiter.sv
// Round-robin arbiter sharing one mac_core port between NUM_REQ requesters.
// Define ARB_STATS_EN to build per-requester saturating grant counters.
module mac_access_arbiter
  import neural_arb_pkg::*;
#(
  parameter int NUM_REQ    = 2,
  parameter int DATA_W     = DATA_W_DEFAULT,
  parameter int MAX_BURST  = 16,
  parameter int RD_TIMEOUT = 64,
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ-1:0]        req_rd,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_cs,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]         rsp_data,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rd_timeout_err,
  output logic [DATA_W-1:0]         mac_data_in,
  output logic                      mac_wr_en,
  output logic                      mac_rd_en,
  output logic                      mac_chip_sel,
  input  logic [DATA_W-1:0]         mac_data_out,
  input  logic                      mac_output_ready,
  input  logic [IW-1:0]             stat_sel,
  output logic [STAT_W-1:0]         stat_count
);

  localparam int BW = $clog2(MAX_BURST + 1);
  localparam int TW = $clog2(RD_TIMEOUT + 1);

  arb_state_t         state, nxt;
  logic [NUM_REQ-1:0] own;
  logic [IW-1:0]      last;
  logic [BW-1:0]      beat_cnt;
  logic               rd_pending;
  logic [TW-1:0]      tmr;

  logic [NUM_REQ-1:0] pick;
  logic [IW-1:0]      pick_idx;
  logic               any;
  logic               acc_wr, acc_rd, accept;
  logic               last_beat, tmo, pend_nxt;
  logic               grant_evt;

  rr_pick #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .idx  (pick_idx),
    .any  (any)
  );

  // last always holds the current owner once a grant is issued
  always_comb begin
    mac_data_in  = '0;
    mac_chip_sel = 1'b0;
    acc_wr       = 1'b0;
    acc_rd       = 1'b0;
    if (state == GRANT) begin
      mac_data_in  = req_data[int'(last)*DATA_W +: DATA_W];
      mac_chip_sel = req_cs[last];
      acc_wr       = req_wr[last];
      acc_rd       = req_rd[last] & ~req_wr[last] & ~rd_pending;
    end
  end

  assign mac_wr_en = acc_wr;
  assign mac_rd_en = acc_rd;
  assign accept    = acc_wr | acc_rd;
  assign last_beat = accept && (beat_cnt == BW'(MAX_BURST - 1));

  assign tmo = rd_pending & ~mac_output_ready
             & (tmr == TW'(RD_TIMEOUT));
  assign pend_nxt = acc_rd
                  | (rd_pending & ~mac_output_ready & ~tmo);

  assign rd_timeout_err = tmo;
  assign rsp_data       = mac_data_out;
  assign rsp_valid      = mac_output_ready ? own : '0;
  assign grant_evt      = (state == IDLE) && any;

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:  if (any) nxt = GRANT;
      GRANT: begin
        if (!req[last] || last_beat)
          nxt = pend_nxt ? DRAIN : GAP;
      end
      DRAIN: begin
        if (!rd_pending || mac_output_ready || tmo)
          nxt = GAP;
      end
      GAP:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      gnt        <= '0;
      own        <= '0;
      last       <= IW'(NUM_REQ - 1);
      beat_cnt   <= '0;
      rd_pending <= 1'b0;
      tmr        <= '0;
    end else begin
      state      <= nxt;
      rd_pending <= pend_nxt;
      if (acc_rd)
        tmr <= TW'(1);
      else if (rd_pending && tmr != TW'(RD_TIMEOUT))
        tmr <= tmr + 1'b1;
      if (grant_evt) begin
        gnt      <= pick;
        own      <= pick;
        last     <= pick_idx;
        beat_cnt <= '0;
      end
      if (state == GRANT) begin
        beat_cnt <= beat_cnt + BW'(accept);
        if (nxt != GRANT) gnt <= '0;
      end
      if (state != GAP && nxt == GAP)
        own <= '0;
    end
  end

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] cnt [NUM_REQ];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REQ; i++) cnt[i] <= '0;
    end else if (grant_evt) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (pick[i]) cnt[i] <= sat_inc(cnt[i]);
    end
  end

  assign stat_count = (int'(stat_sel) < NUM_REQ) ? cnt[stat_sel] : '0;
`else
  logic unused_stat_sel;

  assign unused_stat_sel = ^stat_sel;
  assign stat_count      = '0;
`endif

endmodule
